instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Upstream stage of the processor: after start, fetches 24-bit instruction words from program
//  memory at a sequential PC and hands each to the processor on func/new_func. Waits for the
//  processor's proc_done before fetching the next word; stops on the HALT opcode.
// PARAMETERS
//  ADDR_W   8      program-memory address width; PC wraps modulo 2**ADDR_W
//  DATA_W   24     instruction width (matches processor func)
//  MEM_LAT  1      read latency in cycles, mem_rd to valid mem_rdata (legal 1..4)
//  HALT_OP  4'hF   value of func[DATA_W-1 -: 4] that ends the program
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       begin fetching from PC 0 (sampled in IDLE/HALT only)
//  mem_enable  in   1       memory available; read is issued only when high
//  mem_rd      out  1       read strobe, one cycle per fetch
//  mem_addr    out  ADDR_W  read address (= pc while mem_rd high)
//  mem_rdata   in   DATA_W  read data, valid MEM_LAT cycles after mem_rd
//  func        out  DATA_W  instruction to processor, held stable until next issue
//  new_func    out  1       one-cycle pulse: func holds a new instruction
//  proc_done   in   1       processor finished current func
//  pc          out  ADDR_W  address of the instruction currently issued/being fetched
//  halted      out  1       high while in HALT
// BEHAVIOUR
//  Reset (sync): state=IDLE; pc=0, func=0, new_func=0, mem_rd=0, mem_addr=0, halted=0. Reset
//   wins over every other input, including mid-fetch or mid-exec; any in-flight read is discarded.
//  FSM states: IDLE, REQ, WAIT, ISSUE, EXEC, HALT.
//  IDLE: outputs idle. start=1 -> pc=0, REQ.
//  REQ: if mem_enable: mem_rd=1, mem_addr=pc for this cycle -> WAIT, lat_cnt=MEM_LAT-1.
//   if !mem_enable: mem_rd=0, stay REQ (no timeout).
//  WAIT: decrement lat_cnt; at lat_cnt==0 sample mem_rdata into func at that edge -> ISSUE.
//   mem_enable dropping during WAIT does not abort the read.
//  ISSUE: new_func=1 for exactly this cycle. If func[DATA_W-1 -: 4]==HALT_OP -> HALT
//   (HALT word is still issued to the processor); else -> EXEC. proc_done here is ignored.
//  EXEC: wait for proc_done=1; on that edge pc<=pc+1 (wraps 2**ADDR_W-1 -> 0, no halt on wrap)
//   -> REQ. No limit on EXEC duration.
//  HALT: halted=1, func holds HALT word. start=1 -> pc=0, halted=0, REQ. proc_done ignored.
//  start outside IDLE/HALT ignored. mem_rd never high outside REQ; at most one read outstanding.
//  Latency (MEM_LAT=L, mem_enable=1): start sampled at edge E0; mem_rd high in cycle E0..E1;
//   func loaded at edge E1+L; new_func high in cycle after it. proc_done at edge Ed -> next
//   mem_rd high in cycle after Ed. Fetch-to-issue = L+1 cycles.
//  func/pc change only at load/increment edges; stable while new_func=0.
// TESTING
//  1 Reset: reset=1 two cycles with start=1 -> func=0, new_func=0, mem_rd=0, pc=0, halted=0.
//  2 Program {0x100001,0x200002,0xF00000}, L=1, proc_done 3 cycles after each new_func ->
//    new_func pulses 3x with func 0x100001,0x200002,0xF00000 at mem_addr 0,1,2; halted=1 after.
//  3 mem_enable=0 for 5 cycles in REQ -> mem_rd stays 0, no new_func; releases -> fetch resumes.
//  4 MEM_LAT=3 -> new_func asserted exactly 4 cycles after mem_rd; early mem_rdata not sampled.
//  5 ADDR_W=2, no HALT word, proc_done immediate -> mem_addr sequence 0,1,2,3,0,1; halted=0.
//  6 reset mid-WAIT and mid-EXEC -> next cycle IDLE, pc=0, no new_func; start re-fetches addr 0.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - sequential instruction fetch stage with halt detection
module instr_fetch #(
  parameter int         ADDR_W  = 8,
  parameter int         DATA_W  = 24,
  parameter int         MEM_LAT = 1,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_enable,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] func,
  output logic              new_func,
  input  logic              proc_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_t;

  // Latency counter reloads with MEM_LAT-1 so the data edge lands MEM_LAT
  // cycles after the read strobe; 2 bits cover latencies 1..4.
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_t     state;
  logic [1:0] lat_cnt;

  // Read strobe follows mem_enable in the same cycle so a request is never
  // issued against a memory that is not available.
  assign mem_rd   = (state == S_REQ) && mem_enable;
  assign mem_addr = mem_rd ? pc : '0;

  // Fetch sequencing: request, wait out the read latency, issue, then hold
  // until the processor reports completion or the program halts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      lat_cnt  <= 2'd0;
      pc       <= '0;
      func     <= '0;
      new_func <= 1'b0;
      halted   <= 1'b0;
    end else begin
      new_func <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_enable) begin
            lat_cnt <= LAT_INIT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            func     <= mem_rdata;
            new_func <= 1'b1;
            state    <= S_ISSUE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_ISSUE: begin
          // The halt word has already been presented to the processor.
          if (func[DATA_W-1 -: 4] == HALT_OP) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (proc_done) begin
            pc    <= pc + ADDR_W'(1);
            state <= S_REQ;
          end
        end
        S_HALT: begin
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic          reset_i  [2];
  logic          start_i  [2];
  logic          en_i     [2];
  logic          done_i   [2];
  logic [DW-1:0] prog     [2][256];

  logic          nf_o     [2];
  logic          halted_o [2];
  logic [31:0]   pc_o     [2];
  logic [31:0]   func_o   [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instance 0: ADDR_W=8, MEM_LAT=1.  Instance 1: ADDR_W=2, MEM_LAT=3.
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int AW = (g == 0) ? 8 : 2;
    localparam int L  = (g == 0) ? 1 : 3;

    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] func;
    logic          new_func;
    logic [AW-1:0] pc;
    logic          halted;

    logic [31:0] log_addr [$];
    logic [31:0] log_func [$];
    int          rd_cyc   [$];
    int          nf_cyc   [$];

    instr_fetch #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .MEM_LAT(L),
      .HALT_OP(4'hF)
    ) dut (
      .clk       (clk),
      .reset     (reset_i[g]),
      .start     (start_i[g]),
      .mem_enable(en_i[g]),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .func      (func),
      .new_func  (new_func),
      .proc_done (done_i[g]),
      .pc        (pc),
      .halted    (halted)
    );

    assign nf_o[g]     = new_func;
    assign halted_o[g] = halted;
    assign pc_o[g]     = 32'(pc);
    assign func_o[g]   = 32'(func);

    // Program memory: data is valid only in the single cycle L cycles after
    // the read; every other cycle carries junk so early sampling shows up.
    logic [DW:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= mem_rd ? {1'b1, prog[g][mem_addr]} : '0;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1][DW] ? pipe[L-1][DW-1:0] : 24'hBADBAD;

    // Reference model: a fetch request is pending until memory is enabled,
    // the word at pc appears L+1 cycles after its read, then the fetcher
    // either halts or waits for proc_done before moving to pc+1.
    initial begin : chk
      bit            known = 1'b0;
      bit            idle = 1'b1, need = 1'b0, execw = 1'b0, hlt = 1'b0;
      bit            was_issue, e_rd;
      int            issue_cyc = -1;
      int            n = 0;
      logic [AW-1:0] e_pc = '0;
      logic [DW-1:0] e_func = '0;
      bit            e_newf = 1'b0, e_halted = 1'b0;
      forever begin
        @(negedge clk);
        if (known) begin
          e_rd = need && en_i[g];
          check($sformatf("u%0d.mem_rd", g), 32'(mem_rd), 32'(e_rd));
          if (e_rd) check($sformatf("u%0d.mem_addr", g), 32'(mem_addr), 32'(e_pc));
          check($sformatf("u%0d.func", g), 32'(func), 32'(e_func));
          check($sformatf("u%0d.new_func", g), 32'(new_func), 32'(e_newf));
          check($sformatf("u%0d.pc", g), 32'(pc), 32'(e_pc));
          check($sformatf("u%0d.halted", g), 32'(halted), 32'(e_halted));
          if (mem_rd === 1'b1) begin
            log_addr.push_back(32'(mem_addr));
            rd_cyc.push_back(n);
          end
          if (new_func === 1'b1) begin
            log_func.push_back(32'(func));
            nf_cyc.push_back(n);
          end
        end
        if (reset_i[g]) begin
          known = 1'b1; idle = 1'b1; need = 1'b0; execw = 1'b0; hlt = 1'b0;
          issue_cyc = -1; e_pc = '0; e_func = '0; e_newf = 1'b0; e_halted = 1'b0;
        end else if (known) begin
          was_issue = e_newf;
          e_newf = 1'b0;
          if ((idle || hlt) && start_i[g]) begin
            idle = 1'b0; hlt = 1'b0; e_halted = 1'b0; e_pc = '0; need = 1'b1;
          end else if (need && en_i[g]) begin
            need = 1'b0;
            issue_cyc = n + L + 1;
          end else if (issue_cyc == n + 1) begin
            issue_cyc = -1;
            e_func = prog[g][e_pc];
            e_newf = 1'b1;
          end else if (was_issue) begin
            if (e_func[DW-1 -: 4] == 4'hF) begin
              hlt = 1'b1; e_halted = 1'b1;
            end else begin
              execw = 1'b1;
            end
          end else if (execw && done_i[g]) begin
            execw = 1'b0;
            e_pc = e_pc + AW'(1);
            need = 1'b1;
          end
        end
        n++;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_newf(input int g, input int budget);
    int i = 0;
    while (nf_o[g] !== 1'b1 && i < budget) begin
      tick(1);
      i++;
    end
    check($sformatf("u%0d.new_func_timeout", g), 32'(nf_o[g]), 32'd1);
  endtask

  task automatic pulse_done(input int g);
    tick(3);
    done_i[g] = 1'b1;
    tick(1);
    done_i[g] = 1'b0;
  endtask

  task automatic clear_logs0();
    u[0].log_addr.delete(); u[0].log_func.delete();
    u[0].rd_cyc.delete();   u[0].nf_cyc.delete();
  endtask

  logic [31:0] exp_f [3];
  logic [31:0] exp_a [6];

  initial begin
    for (int g = 0; g < 2; g++) begin
      for (int a = 0; a < 256; a++) prog[g][a] = '0;
      reset_i[g] = 1'b1; start_i[g] = 1'b1; en_i[g] = 1'b1; done_i[g] = 1'b0;
    end
    prog[0][0] = 24'h100001; prog[0][1] = 24'h200002; prog[0][2] = 24'hF00000;
    prog[1][0] = 24'h111111; prog[1][1] = 24'h222222;
    prog[1][2] = 24'h333333; prog[1][3] = 24'h444444;

    // Reset held two cycles with start asserted: everything idle.
    tick(2);
    check("rst.pc", pc_o[0], 32'd0);
    check("rst.func", func_o[0], 32'd0);
    check("rst.new_func", 32'(nf_o[0]), 32'd0);
    check("rst.halted", 32'(halted_o[0]), 32'd0);
    for (int g = 0; g < 2; g++) begin reset_i[g] = 1'b0; start_i[g] = 1'b0; end
    tick(1);

    // Three-word program ending in HALT.
    clear_logs0();
    start_i[0] = 1'b1; tick(1); start_i[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_newf(0, 20);
      pulse_done(0);
    end
    exp_f = '{32'h100001, 32'h200002, 32'hF00000};
    check("prog.issue_count", 32'(u[0].log_func.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("prog.func%0d", k), u[0].log_func[k], exp_f[k]);
      check($sformatf("prog.addr%0d", k), u[0].log_addr[k], 32'(k));
    end
    check("prog.halted", 32'(halted_o[0]), 32'd1);

    // Memory unavailable for 5 cycles after restart from HALT.
    clear_logs0();
    en_i[0] = 1'b0;
    start_i[0] = 1'b1; tick(1); start_i[0] = 1'b0;
    tick(5);
    check("stall.no_read", 32'(u[0].log_addr.size()), 32'd0);
    check("stall.no_issue", 32'(u[0].log_func.size()), 32'd0);
    en_i[0] = 1'b1;
    wait_newf(0, 20);
    check("stall.resume_func", func_o[0], 32'h100001);
    check("stall.resume_addr", u[0].log_addr[0], 32'd0);
    reset_i[0] = 1'b1; tick(1); reset_i[0] = 1'b0;

    // Reset during the read-latency wait.
    start_i[0] = 1'b1; tick(1); start_i[0] = 1'b0;
    tick(1);
    reset_i[0] = 1'b1; tick(1); reset_i[0] = 1'b0;
    clear_logs0();
    tick(3);
    check("rst_wait.no_issue", 32'(u[0].log_func.size()), 32'd0);
    check("rst_wait.pc", pc_o[0], 32'd0);

    // Re-fetch from 0, then reset while the second word executes.
    start_i[0] = 1'b1; tick(1); start_i[0] = 1'b0;
    wait_newf(0, 20);
    check("refetch.addr", u[0].log_addr[0], 32'd0);
    check("refetch.func", func_o[0], 32'h100001);
    pulse_done(0);
    wait_newf(0, 20);
    check("exec.pc_before", pc_o[0], 32'd1);
    tick(2);
    reset_i[0] = 1'b1; tick(1); reset_i[0] = 1'b0;
    check("rst_exec.pc", pc_o[0], 32'd0);
    check("rst_exec.new_func", 32'(nf_o[0]), 32'd0);

    // MEM_LAT=3 latency and ADDR_W=2 wrap with immediate proc_done.
    done_i[1] = 1'b1;
    start_i[1] = 1'b1; tick(1); start_i[1] = 1'b0;
    for (int i = 0; i < 200 && u[1].log_addr.size() < 6; i++) tick(1);
    check("wrap.read_count", 32'(u[1].log_addr.size() >= 6), 32'd1);
    exp_a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    for (int k = 0; k < 6; k++)
      check($sformatf("wrap.addr%0d", k), u[1].log_addr[k], exp_a[k]);
    check("lat3.rd_to_issue", 32'(u[1].nf_cyc[0] - u[1].rd_cyc[0]), 32'd4);
    check("lat3.func0", u[1].log_func[0], 32'h111111);
    check("lat3.func3", u[1].log_func[3], 32'h444444);
    check("wrap.halted", 32'(halted_o[1]), 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
